// File: rtl/pipe_delay_line_if.sv
// Sample/control bundle for pipe_delay_line: stall, flush, delay select, data in/out.
// master drives the i_* signals; slave (the delay line) drives the o_* signals.
interface pipe_delay_line_if #(
   parameter int WIDTH   = 8,
   parameter int MAX_DLY = 16
);
   localparam int DW = $clog2(MAX_DLY + 1);

   logic             i_en;
   logic             i_flush;
   logic [DW-1:0]    i_dly_sel;
   logic [WIDTH-1:0] i_din;
   logic             i_din_vld;
   logic [WIDTH-1:0] o_dout;
   logic             o_dout_vld;
   logic             o_dly_busy;

   modport master (
      output i_en, i_flush, i_dly_sel, i_din, i_din_vld,
      input  o_dout, o_dout_vld, o_dly_busy
   );

   modport slave (
      input  i_en, i_flush, i_dly_sel, i_din, i_din_vld,
      output o_dout, o_dout_vld, o_dly_busy
   );
endinterface

// File: rtl/pipe_delay_line.sv
// Runtime-programmable delay line with valid masking after delay changes.
// Optional macro PIPE_DELAY_OUTREG_EN adds an en-gated output register (latency +1).
module pipe_delay_line #(
   parameter int WIDTH   = 8,
   parameter int MAX_DLY = 16
) (
   input logic                clk,
   input logic                rst,
   pipe_delay_line_if.slave   bus
);
   localparam int DW = $clog2(MAX_DLY + 1);
   localparam int CW = $clog2(MAX_DLY + 2);
   localparam int IW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
`ifdef PIPE_DELAY_OUTREG_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif

   typedef enum logic {ST_RUN, ST_SETTLE} state_t;

   logic [WIDTH-1:0]   r_stg_data [MAX_DLY];
   logic [MAX_DLY-1:0] r_stg_vld;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [DW-1:0]      r_dly_q;
   logic [DW-1:0]      w_dly_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [DW-1:0]      w_eff;
   logic [IW-1:0]      w_tap_idx;
   logic [WIDTH-1:0]   w_tap_data;
   logic               w_tap_vld;
   logic               w_run;

   // Clamp the requested delay into 1..MAX_DLY
   always_comb begin
      w_eff = bus.i_dly_sel;
      if (bus.i_dly_sel == '0)
         w_eff = DW'(1);
      else if (bus.i_dly_sel > DW'(MAX_DLY))
         w_eff = DW'(MAX_DLY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MAX_DLY; k++)
            r_stg_data[k] <= '0;
         r_stg_vld <= '0;
      end else begin
         if (bus.i_en) begin
            r_stg_data[0] <= bus.i_din;
            for (int k = 1; k < MAX_DLY; k++)
               r_stg_data[k] <= r_stg_data[k-1];
         end
         if (bus.i_flush) begin
            r_stg_vld <= '0;
         end else if (bus.i_en) begin
            r_stg_vld[0] <= bus.i_din_vld;
            for (int k = 1; k < MAX_DLY; k++)
               r_stg_vld[k] <= r_stg_vld[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_dly_q <= DW'(1);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dly_q <= w_dly_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A delay change always (re)starts the mask, even mid-settle and while stalled
   always_comb begin
      w_state_nxt = r_state;
      w_dly_nxt   = r_dly_q;
      w_cnt_nxt   = r_cnt;
      if (w_eff != r_dly_q) begin
         w_dly_nxt   = w_eff;
         w_cnt_nxt   = CW'(w_eff) + CW'(XL);
         w_state_nxt = ST_SETTLE;
      end else if ((r_state == ST_SETTLE) && bus.i_en) begin
         if (r_cnt == CW'(1)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt - CW'(1);
         end
      end
   end

   assign w_tap_idx      = IW'(r_dly_q - DW'(1));
   assign w_tap_data     = r_stg_data[w_tap_idx];
   assign w_tap_vld      = r_stg_vld[w_tap_idx];
   assign w_run          = (r_state == ST_RUN);
   assign bus.o_dly_busy = (r_state == ST_SETTLE);

`ifdef PIPE_DELAY_OUTREG_EN
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
      end else begin
         if (bus.i_en)
            r_out_data <= w_tap_data;
         if (bus.i_flush)
            r_out_vld <= 1'b0;
         else if (bus.i_en)
            r_out_vld <= w_tap_vld;
      end
   end

   // The extra mask cycle covers the register stage; gating by RUN keeps stale data invalid
   assign bus.o_dout     = r_out_data;
   assign bus.o_dout_vld = r_out_vld & w_run;
`else
   assign bus.o_dout     = w_tap_data;
   assign bus.o_dout_vld = w_tap_vld & w_run;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: settle masking, clamping, stall, flush, reset.
module tb_pipe_delay_line;
   localparam int WIDTH   = 8;
   localparam int MAX_DLY = 16;
   localparam int DW      = $clog2(MAX_DLY + 1);
`ifdef PIPE_DELAY_OUTREG_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_err = 0;
   int         n_chk = 0;
   logic [7:0] last;
   logic [7:0] exp_d;

   pipe_delay_line_if #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) bus();

   pipe_delay_line #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push();
      last          = last + 8'd1;
      bus.i_din     = last;
      bus.i_din_vld = 1'b1;
      tick();
   endtask

   // Program a delay, count masked cycles, then check the aligned sample
   task automatic settle(input int sel, input int eff, input string tag);
      int n;
      n = 0;
      bus.i_dly_sel = DW'(sel);
      do begin
         push();
         n++;
         if (bus.o_dly_busy)
            chk({tag, "_mask"}, 32'(bus.o_dout_vld), 32'd0);
      end while (bus.o_dly_busy && n < 40);
      chk({tag, "_busy_len"}, n - 1, eff + XL);
      exp_d = last - 8'(eff - 1 + XL);
      chk({tag, "_dout"}, 32'(bus.o_dout), 32'(exp_d));
      chk({tag, "_vld"}, 32'(bus.o_dout_vld), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.i_en      = 1'b1;
      bus.i_flush   = 1'b0;
      bus.i_dly_sel = DW'(3);
      bus.i_din     = '0;
      bus.i_din_vld = 1'b0;
      last          = 8'd0;
      repeat (2) tick();
      chk("rst_dout", 32'(bus.o_dout), 32'd0);
      chk("rst_vld", 32'(bus.o_dout_vld), 32'd0);
      chk("rst_busy", 32'(bus.o_dly_busy), 32'd0);

      // Delay 3 from reset: change seen on first edge, then 0x01.. stream
      rst = 1'b0;
      tick();
      chk("s1_busy_e0", 32'(bus.o_dly_busy), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         push();
         chk("s1_busy", 32'(bus.o_dly_busy), (i < 3 + XL) ? 32'd1 : 32'd0);
         if (i >= 3 + XL) begin
            chk("s1_dout", 32'(bus.o_dout), 32'(i - 2 - XL));
            chk("s1_vld", 32'(bus.o_dout_vld), 32'd1);
         end else begin
            chk("s1_mask", 32'(bus.o_dout_vld), 32'd0);
         end
      end

      // Clamping of out-of-range selects
      settle(0, 1, "sel0");
      settle(MAX_DLY + 5, MAX_DLY, "selmax");

      // Mid-stream change 4 -> 2
      settle(4, 4, "d4");
      for (int i = 0; i < 3; i++) begin
         push();
         exp_d = last - 8'(3 + XL);
         chk("d4_stream", 32'(bus.o_dout), 32'(exp_d));
      end
      settle(2, 2, "d4to2");

      // Stall at delay 2: outputs frozen, only enabled edges count
      exp_d         = last - 8'(1 + XL);
      bus.i_en      = 1'b0;
      bus.i_din     = 8'hEE;
      repeat (2) tick();
      chk("stall_dout", 32'(bus.o_dout), 32'(exp_d));
      chk("stall_vld", 32'(bus.o_dout_vld), 32'd1);
      bus.i_en = 1'b1;
      push();
      exp_d = last - 8'(1 + XL);
      chk("stall_resume", 32'(bus.o_dout), 32'(exp_d));

      // Settle counter frozen by stall
      bus.i_dly_sel = DW'(3);
      push();
      chk("stall_settle_e0", 32'(bus.o_dly_busy), 32'd1);
      bus.i_en  = 1'b0;
      bus.i_din = 8'hEE;
      repeat (3) begin
         tick();
         chk("stall_settle_busy", 32'(bus.o_dly_busy), 32'd1);
         chk("stall_settle_mask", 32'(bus.o_dout_vld), 32'd0);
      end
      bus.i_en = 1'b1;
      for (int k = 0; k < 2 + XL; k++) begin
         push();
         chk("stall_settle_cnt", 32'(bus.o_dly_busy), 32'd1);
      end
      push();
      chk("stall_settle_done", 32'(bus.o_dly_busy), 32'd0);
      exp_d = last - 8'(2 + XL);
      chk("stall_settle_dout", 32'(bus.o_dout), 32'(exp_d));
      chk("stall_settle_vld", 32'(bus.o_dout_vld), 32'd1);

      // Flush with a full line at delay 5
      settle(5, 5, "d5");
      repeat (2) push();
      bus.i_flush = 1'b1;
      push();
      bus.i_flush = 1'b0;
      chk("flush_e0", 32'(bus.o_dout_vld), 32'd0);
      for (int k = 1; k <= 4 + XL; k++) begin
         push();
         chk("flush_mask", 32'(bus.o_dout_vld), 32'd0);
      end
      push();
      chk("flush_vld", 32'(bus.o_dout_vld), 32'd1);
      exp_d = last - 8'(4 + XL);
      chk("flush_dout", 32'(bus.o_dout), 32'(exp_d));
      chk("flush_busy", 32'(bus.o_dly_busy), 32'd0);

      // Asynchronous reset in the middle of a settle
      bus.i_dly_sel = DW'(7);
      push();
      chk("rst2_pre_busy", 32'(bus.o_dly_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst2_dout", 32'(bus.o_dout), 32'd0);
      chk("rst2_vld", 32'(bus.o_dout_vld), 32'd0);
      chk("rst2_busy", 32'(bus.o_dly_busy), 32'd0);
      tick();
      rst = 1'b0;
      settle(7, 7, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
